output_collector: RTL and testbench
===================================

Name: output_collector

Overview:
- Sits directly downstream of the 2x2 systolic array; the array's bottom-row PEs emit accumulated results, skewed in time by column.
- Captures the skewed per-column result beats and de-skews them into an aligned 2x2 result matrix.
- Presents the matrix with a valid/ready handshake to the writeback/unified-buffer stage.
- Mirrors the input-side skewing stage: column 1 results lead column 2 by one cycle.

Parameters:
- ACC_WIDTH, 32, width of each accumulated result word
- TIMEOUT_CYCLES, 15, maximum COLLECT cycles before forced completion; legal range 4..255

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset; deassertion is synchronous to clk
- start  input  1  pulse; arms collection for one matrix (issued with the first input-setup valid)
- acc_in1  input  ACC_WIDTH  result beat from column 1 (bottom PE)
- acc_valid1  input  1  acc_in1 valid this cycle
- acc_in2  input  ACC_WIDTH  result beat from column 2 (bottom PE)
- acc_valid2  input  1  acc_in2 valid this cycle
- c11, c12, c21, c22  output  ACC_WIDTH each  de-skewed result matrix, row-major (cRC)
- result_valid  output  1  matrix complete and stable
- result_ready  input  1  consumer accepts the matrix
- busy  output  1  high in COLLECT or DONE
- overflow  output  1  sticky: beat arrived that could not be stored
- timeout  output  1  set when the current matrix was completed by timeout

Behaviour:
- Reset (reset==0): state=IDLE, all cRC=0, result_valid=0, busy=0, overflow=0, timeout=0, per-column row counters=0, timeout counter=0. Reset mid-operation abandons any partial matrix.
- State machine: IDLE -> COLLECT -> DONE -> IDLE.
- IDLE:
  - start==1 at an edge: clear cRC, row counters, timeout counter, overflow and timeout; go to COLLECT.
  - Beats arriving in IDLE are ignored and do not set overflow.
- COLLECT, per column k at each edge with acc_valid_k==1:
  - If row_k < 2: store acc_in_k into c[row_k+1][k], then row_k++.
  - If row_k == 2: drop the beat and set overflow=1.
  - Columns are independent; both may capture on the same edge.
- COLLECT, timeout counter:
  - Increments every COLLECT cycle.
  - Completion (both row counters reach 2, counting this edge's captures) at the same edge -> DONE, result_valid=1 registered on that edge.
  - Latency: last beat edge -> result_valid visible the following cycle, i.e. zero extra register stages.
  - Timeout counter reaching TIMEOUT_CYCLES-1 without completion -> DONE with timeout=1 and result_valid=1. Uncaptured entries stay 0.
  - Completion and timeout on the same edge: completion wins, timeout=0.
- start is ignored outside IDLE.
- DONE:
  - cRC hold stable while result_valid==1.
  - Any acc_valid_k==1 sets overflow=1; the beat is dropped.
  - result_valid && result_ready at an edge -> IDLE, result_valid=0 next cycle; cRC retain their values until the next start.
  - result_ready while result_valid==0 has no effect.
- busy = (state != IDLE), registered.
- overflow and timeout are sticky until the next accepted start or reset.
- Arithmetic: pure capture, no arithmetic on data; counters are 2-bit (rows) and 8-bit (timeout), no wrap permitted.

Decomposition:
- Shared package tpu_pkg:
  - collector state enum (IDLE, COLLECT, DONE)
  - ARRAY_DIM=2
  - default ACC_WIDTH constant
- One natural sub-module, column_capture: instantiated per column; holds the row counter and two result registers, flags its own overflow and full status; the parent FSM combines the full flags.

Test Plan:
- Nominal skew: start; acc_in1=5 (cycle 1), acc_in1=7 and acc_in2=6 (cycle 2), acc_in2=8 (cycle 3); result_ready=1 -> result_valid high in cycle 4 with c11=5, c21=7, c12=6, c22=8; overflow=0, timeout=0; IDLE and busy=0 after the handshake.
- Backpressure: same beats, result_ready=0 for 5 cycles -> result_valid and cRC stable all 5 cycles; result_ready=1 -> result_valid drops next cycle.
- Overflow: a third acc_valid1 beat (value 99) in COLLECT -> overflow=1, c11/c21 unchanged; a beat during DONE also sets overflow; both flags clear on the next start.
- Timeout: start, only column 1 delivers 2 beats, TIMEOUT_CYCLES=15 -> result_valid after 15 COLLECT cycles with timeout=1, c12=c22=0; completion on the final timeout edge -> timeout=0.
- Reset mid-COLLECT: assert reset low asynchronously after one beat -> all outputs 0 immediately, without waiting for a clock edge; a fresh start then collects correctly.
- start while busy: pulse start in COLLECT and in DONE -> ignored; counters and captured data unaffected.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array result path.
package tpu_pkg;

  localparam int ARRAY_DIM         = 2;
  localparam int DEFAULT_ACC_WIDTH = 32;

  // Result collector sequencing: arm on start, gather beats, hold for handshake.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } collector_state_e;

endpackage

// File: rtl/output_collector_column_capture.sv
// Per-column capture: stores up to ARRAY_DIM result beats in row order and
// reports when a beat has to be dropped because the column is already full.
module column_capture
  import tpu_pkg::*;
#(
  parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 acc_valid,
  input  logic [ACC_WIDTH-1:0] acc_in,
  output logic [ACC_WIDTH-1:0] row1_data,
  output logic [ACC_WIDTH-1:0] row2_data,
  output logic                 full_next,
  output logic                 drop
);

  localparam logic [1:0] ROWS = 2'(ARRAY_DIM);

  logic [1:0] row;
  logic       full;
  logic       store;

  // A beat is stored only while enabled and a row slot is still free.
  always_comb begin
    full      = (row == ROWS);
    store     = enable && acc_valid && !full;
    drop      = enable && acc_valid && full;
    // Full after this edge, counting a capture that happens on it.
    full_next = full || (store && (row == ROWS - 2'd1));
  end

  // Row counter and result registers; clear wipes the previous matrix.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row       <= '0;
      row1_data <= '0;
      row2_data <= '0;
    end else if (clear) begin
      row       <= '0;
      row1_data <= '0;
      row2_data <= '0;
    end else if (store) begin
      if (row == 2'd0) row1_data <= acc_in;
      else             row2_data <= acc_in;
      row <= row + 2'd1;
    end
  end

endmodule

// File: rtl/output_collector.sv
// De-skews the bottom-row results of the 2x2 systolic array into an aligned
// matrix and offers it downstream with a valid/ready handshake.
//
// Handshake: result_valid rises when the matrix is complete (or timed out)
// and stays high with c11..c22 stable until an edge where result_ready is
// also high; that edge transfers the matrix and result_valid falls next
// cycle. result_ready has no effect while result_valid is low.
// TIMEOUT_CYCLES must lie in 4..255 so the 8-bit counter never wraps.
module output_collector
  import tpu_pkg::*;
#(
  parameter int ACC_WIDTH      = DEFAULT_ACC_WIDTH,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ACC_WIDTH-1:0] acc_in1,
  input  logic                 acc_valid1,
  input  logic [ACC_WIDTH-1:0] acc_in2,
  input  logic                 acc_valid2,
  output logic [ACC_WIDTH-1:0] c11,
  output logic [ACC_WIDTH-1:0] c12,
  output logic [ACC_WIDTH-1:0] c21,
  output logic [ACC_WIDTH-1:0] c22,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 busy,
  output logic                 overflow,
  output logic                 timeout,
  output collector_state_e     state
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  collector_state_e state_q, state_d;
  logic [7:0]       tcnt;
  logic             start_accept;
  logic             collecting;
  logic             complete;
  logic             tmo_last;
  logic             full_next1, full_next2;
  logic             drop1, drop2;

  assign start_accept = (state_q == IDLE) && start;
  assign collecting   = (state_q == COLLECT);
  assign complete     = full_next1 && full_next2;
  assign tmo_last     = (tcnt == TIMEOUT_LAST);
  assign state        = state_q;

  column_capture #(.ACC_WIDTH(ACC_WIDTH)) u_col1 (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_accept),
    .enable    (collecting),
    .acc_valid (acc_valid1),
    .acc_in    (acc_in1),
    .row1_data (c11),
    .row2_data (c21),
    .full_next (full_next1),
    .drop      (drop1)
  );

  column_capture #(.ACC_WIDTH(ACC_WIDTH)) u_col2 (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_accept),
    .enable    (collecting),
    .acc_valid (acc_valid2),
    .acc_in    (acc_in2),
    .row1_data (c12),
    .row2_data (c22),
    .full_next (full_next2),
    .drop      (drop2)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: completion or timeout ends collection; handshake returns to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)                 state_d = COLLECT;
      COLLECT: if (complete || tmo_last)  state_d = DONE;
      DONE:    if (result_ready)          state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state register, so they change only on edges.
  always_comb begin
    result_valid = (state_q == DONE);
    busy         = (state_q != IDLE);
  end

  // Timeout counter and sticky flags, all cleared by an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt     <= '0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else if (start_accept) begin
      tcnt     <= '0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (collecting && !tmo_last) tcnt <= tcnt + 8'd1;
      // Completion on the final timeout edge takes priority over timeout.
      if (collecting && tmo_last && !complete) timeout <= 1'b1;
      if ((collecting && (drop1 || drop2)) ||
          ((state_q == DONE) && (acc_valid1 || acc_valid2)))
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_output_collector.sv
// Directed bench for output_collector: nominal skew, backpressure, overflow,
// timeout, asynchronous reset and start-while-busy.
module tb_output_collector;
  import tpu_pkg::*;

  localparam int W = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic [W-1:0]     acc_in1, acc_in2;
  logic             acc_valid1, acc_valid2;
  logic [W-1:0]     c11, c12, c21, c22;
  logic             result_valid, result_ready;
  logic             busy, overflow, timeout;
  collector_state_e state_w;

  int compared   = 0;
  int mismatched = 0;

  output_collector #(.ACC_WIDTH(W), .TIMEOUT_CYCLES(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .acc_in1      (acc_in1),
    .acc_valid1   (acc_valid1),
    .acc_in2      (acc_in2),
    .acc_valid2   (acc_valid2),
    .c11          (c11),
    .c12          (c12),
    .c21          (c21),
    .c22          (c22),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .overflow     (overflow),
    .timeout      (timeout),
    .state        (state_w)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beats(input logic v1, input logic [W-1:0] d1,
                       input logic v2, input logic [W-1:0] d2);
    acc_valid1 = v1;
    acc_in1    = d1;
    acc_valid2 = v2;
    acc_in2    = d2;
  endtask

  task automatic check_matrix(input string tag, input logic [W-1:0] e11,
                              input logic [W-1:0] e12, input logic [W-1:0] e21,
                              input logic [W-1:0] e22);
    check({tag, ".c11"}, c11, e11);
    check({tag, ".c12"}, c12, e12);
    check({tag, ".c21"}, c21, e21);
    check({tag, ".c22"}, c22, e22);
  endtask

  // Starts a matrix, then delivers the standard skewed 5/7 and 6/8 beats.
  task automatic nominal_fill();
    start = 1'b1; tick(); start = 1'b0;
    beats(1, 5, 0, 0); tick();
    beats(1, 7, 1, 6); tick();
    beats(0, 0, 1, 8); tick();
    beats(0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; result_ready = 1'b0;
    beats(0, 0, 0, 0);

    // Reset state.
    repeat (3) tick();
    check("rst.state", 32'(state_w), 32'(IDLE));
    check("rst.valid", result_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.overflow", overflow, 0);
    check("rst.timeout", timeout, 0);
    check_matrix("rst", 0, 0, 0, 0);
    @(negedge clk); reset = 1'b1;

    // Beats in IDLE are ignored.
    beats(1, 3, 1, 4); tick(); beats(0, 0, 0, 0);
    check("idle_beat.overflow", overflow, 0);
    check("idle_beat.c11", c11, 0);

    // Nominal skew.
    start = 1'b1; tick(); start = 1'b0;
    check("nom.busy", busy, 1);
    check("nom.state", 32'(state_w), 32'(COLLECT));
    beats(1, 5, 0, 0); tick();
    beats(1, 7, 1, 6); tick();
    check("nom.valid_early", result_valid, 0);
    beats(0, 0, 1, 8); result_ready = 1'b1; tick();
    beats(0, 0, 0, 0);
    check("nom.valid", result_valid, 1);
    check_matrix("nom", 5, 6, 7, 8);
    check("nom.overflow", overflow, 0);
    check("nom.timeout", timeout, 0);
    tick();
    result_ready = 1'b0;
    check("nom.valid_after", result_valid, 0);
    check("nom.busy_after", busy, 0);
    check("nom.state_after", 32'(state_w), 32'(IDLE));
    check("nom.c11_retained", c11, 5);

    // Backpressure: valid and data hold for 5 cycles with ready low.
    nominal_fill();
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", result_valid, 1);
      check_matrix("bp", 5, 6, 7, 8);
      if (i < 4) tick();
    end
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    check("bp.valid_drop", result_valid, 0);

    // Overflow in COLLECT: third column-1 beat is dropped.
    start = 1'b1; tick(); start = 1'b0;
    beats(1, 11, 0, 0); tick();
    beats(1, 12, 1, 21); tick();
    beats(1, 99, 0, 0); tick();
    check("ovf.flag", overflow, 1);
    check("ovf.c11", c11, 11);
    check("ovf.c21", c21, 12);
    check("ovf.state", 32'(state_w), 32'(COLLECT));
    beats(0, 0, 1, 22); tick(); beats(0, 0, 0, 0);
    check("ovf.valid", result_valid, 1);
    check_matrix("ovf", 11, 21, 12, 22);
    result_ready = 1'b1; tick(); result_ready = 1'b0;

    // Overflow in DONE: flag clears on start, then a DONE beat sets it.
    start = 1'b1; tick(); start = 1'b0;
    check("ovf_done.cleared", overflow, 0);
    beats(1, 1, 0, 0); tick();
    beats(1, 2, 1, 3); tick();
    beats(0, 0, 1, 4); tick();
    beats(0, 0, 1, 77); tick(); beats(0, 0, 0, 0);
    check("ovf_done.flag", overflow, 1);
    check("ovf_done.c22", c22, 4);
    check("ovf_done.valid", result_valid, 1);
    result_ready = 1'b1; tick(); result_ready = 1'b0;

    // Timeout: only column 1 delivers; DONE on the 15th COLLECT edge.
    start = 1'b1; tick(); start = 1'b0;
    check("tmo.ovf_cleared", overflow, 0);
    for (int e = 1; e <= 14; e++) begin
      if (e == 1)      beats(1, 31, 0, 0);
      else if (e == 2) beats(1, 32, 0, 0);
      else             beats(0, 0, 0, 0);
      tick();
    end
    check("tmo.valid_at14", result_valid, 0);
    check("tmo.state_at14", 32'(state_w), 32'(COLLECT));
    tick();
    check("tmo.valid", result_valid, 1);
    check("tmo.flag", timeout, 1);
    check_matrix("tmo", 31, 0, 32, 0);
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    check("tmo.sticky", timeout, 1);

    // Completion on the final timeout edge wins.
    start = 1'b1; tick(); start = 1'b0;
    check("tmo_win.cleared", timeout, 0);
    for (int e = 1; e <= 14; e++) begin
      if (e == 1)      beats(1, 41, 0, 0);
      else if (e == 2) beats(1, 42, 1, 51);
      else             beats(0, 0, 0, 0);
      tick();
    end
    beats(0, 0, 1, 52); tick(); beats(0, 0, 0, 0);
    check("tmo_win.valid", result_valid, 1);
    check("tmo_win.timeout", timeout, 0);
    check_matrix("tmo_win", 41, 51, 42, 52);
    result_ready = 1'b1; tick(); result_ready = 1'b0;

    // Asynchronous reset mid-COLLECT.
    start = 1'b1; tick(); start = 1'b0;
    beats(1, 42, 0, 0); tick(); beats(0, 0, 0, 0);
    check("arst.c11_before", c11, 42);
    #2 reset = 1'b0;
    #1;
    check("arst.c11", c11, 0);
    check("arst.busy", busy, 0);
    check("arst.valid", result_valid, 0);
    check("arst.state", 32'(state_w), 32'(IDLE));
    @(negedge clk); reset = 1'b1;
    nominal_fill();
    check("arst.fresh_valid", result_valid, 1);
    check_matrix("arst.fresh", 5, 6, 7, 8);
    result_ready = 1'b1; tick(); result_ready = 1'b0;

    // start while busy is ignored in COLLECT and DONE.
    start = 1'b1; tick(); start = 1'b0;
    beats(1, 1, 0, 0); tick();
    start = 1'b1; beats(1, 2, 1, 3); tick(); start = 1'b0;
    check("sbusy.state", 32'(state_w), 32'(COLLECT));
    check("sbusy.c11", c11, 1);
    check("sbusy.c21", c21, 2);
    check("sbusy.c12", c12, 3);
    beats(0, 0, 1, 4); tick(); beats(0, 0, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    check("sbusy.done_state", 32'(state_w), 32'(DONE));
    check("sbusy.done_valid", result_valid, 1);
    check_matrix("sbusy.done", 1, 3, 2, 4);
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    check("sbusy.idle", 32'(state_w), 32'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
